zled_code_blinker: RTL and testbench
====================================

// Module: zled_code_blinker
// PURPOSE
//   Upstream driver for the board status LED. Accepts a status code over a
//   valid/ready handshake and renders it as N blinks (N = code value), then a
//   dark gap, repeating until a new code is sequenced in. Provides a one-deep
//   pending buffer so producers never interrupt a running blink sequence.
// PARAMETERS
//   CODE_W      4           width of status code; max blink count 2**CODE_W-1
//   ON_CYCLES   12_000_000  iClk cycles LED is lit per blink (>=1)
//   OFF_CYCLES  13_000_000  iClk cycles LED is dark between blinks (>=1)
//   GAP_CYCLES  50_000_000  iClk cycles LED is dark after last blink (>=1)
// PORTS
//   iClk        in   1       system clock
//   iRst        in   1       synchronous reset, active high
//   iCode       in   CODE_W  requested status code
//   iCodeValid  in   1       iCode valid
//   oCodeReady  out  1       block can accept a code (pending buffer empty)
//   oLed        out  1       LED drive, 1 = lit
//   oBusy       out  1       1 while a non-zero code is being sequenced
//   oSeqDone    out  1       1-cycle pulse at end of each GAP
// BEHAVIOUR
//   Reset (iRst high at rising edge): state IDLE, oLed=0, oCodeReady=1,
//     oBusy=0, oSeqDone=0, active code=0, pending buffer cleared, counters=0.
//     Applies mid-sequence too; a pending code is dropped.
//   Handshake: transfer when iCodeValid & oCodeReady at a rising edge; code
//     stored in pending buffer. oCodeReady = !pending_full (registered).
//     iCode must be held stable while iCodeValid & !oCodeReady.
//   States: IDLE, ON, OFF, GAP. Phase counter (32b) counts 0..X-1, clears
//     on every state change; blink counter CODE_W bits counts down.
//   IDLE: if pending_full: active<=pending, pending cleared; code!=0 -> ON
//     with blinks=code; code==0 -> stay IDLE. Else stay IDLE.
//   ON: after ON_CYCLES cycles -> OFF, blinks decremented on this exit.
//   OFF: after OFF_CYCLES cycles -> ON if blinks!=0, else GAP.
//   GAP: after GAP_CYCLES cycles: oSeqDone=1 for that transition cycle;
//     if pending_full load it as in IDLE (0 -> IDLE, else ON); otherwise
//     reload blinks=active and -> ON (repeat).
//   oLed is a flop, 1 exactly in cycles where state==ON. oBusy = state!=IDLE.
//   Latency: code accepted at edge k (IDLE) -> state ON and oLed=1 after
//     edge k+1; oCodeReady returns 1 after edge k+1.
//   Pending consumed on same edge as new valid: ready was 0 that cycle, no
//     transfer; producer retries, accepted next edge.
//   A new code never truncates a running sequence; it takes effect only at
//     IDLE or end of GAP. Repeated identical code is still a fresh sequence.
//   Sequence period for code N: N*(ON_CYCLES+OFF_CYCLES)+GAP_CYCLES cycles.
//   No wrap issues: counters bounded by parameters; CODE_W=4 -> 1..15 blinks.
// TESTING  (bench params ON=3, OFF=2, GAP=5, CODE_W=4)
//   Reset: iRst=1 2 cycles -> oLed=0, oCodeReady=1, oBusy=0, oSeqDone=0.
//   Code 3 at edge 0 -> oLed high edges 1-3, 6-8, 11-13; dark 14-20;
//     oSeqDone pulse at GAP end (period 20); repeats with identical timing.
//   Backpressure: during code-3 run send 2 then 5 -> 2 accepted, ready=0,
//     5 held; after first GAP 2 blinks, 5 accepted, plays after next GAP.
//   Code 0 while running -> current sequence completes, then IDLE, oLed=0,
//     oBusy=0, oCodeReady=1.
//   Reset asserted mid-ON with pending code -> oLed=0 next edge, state IDLE,
//     pending dropped (no blinks after reset released).
//   Code 15 -> exactly 15 blinks per sequence, period 15*5+5=80 cycles.

Source files
------------

// File: rtl/zled_code_blinker.sv
// Status LED blinker: plays an accepted code as N blinks followed by a dark gap,
// repeating until a newly buffered code takes over at the end of a gap.
module zled_code_blinker #(
  parameter int CODE_W     = 4,
  parameter int ON_CYCLES  = 12_000_000,
  parameter int OFF_CYCLES = 13_000_000,
  parameter int GAP_CYCLES = 50_000_000
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [CODE_W-1:0] iCode,
  input  logic              iCodeValid,
  output logic              oCodeReady,
  output logic              oLed,
  output logic              oBusy,
  output logic              oSeqDone
);

  localparam logic [31:0] ON_LAST  = 32'(ON_CYCLES - 1);
  localparam logic [31:0] OFF_LAST = 32'(OFF_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t            state;
  logic [31:0]       phase;
  logic [CODE_W-1:0] blinks;
  logic [CODE_W-1:0] active_code;
  logic [CODE_W-1:0] pending_code;
  logic              pending_full;
  logic              accept;
  logic              pending_nonzero;

  assign accept          = iCodeValid && oCodeReady;
  assign pending_nonzero = (pending_code != '0);

  // Accepting a code and consuming the buffer never coincide: a full buffer
  // holds oCodeReady low, so the ordering of the two updates below is moot.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state        <= IDLE;
      phase        <= '0;
      blinks       <= '0;
      active_code  <= '0;
      pending_code <= '0;
      pending_full <= 1'b0;
      oCodeReady   <= 1'b1;
      oLed         <= 1'b0;
      oBusy        <= 1'b0;
      oSeqDone     <= 1'b0;
    end else begin
      oSeqDone <= 1'b0;
      phase    <= phase + 32'd1;

      if (accept) begin
        pending_code <= iCode;
        pending_full <= 1'b1;
        oCodeReady   <= 1'b0;
      end

      case (state)
        IDLE: begin
          phase <= '0;
          if (pending_full) begin
            active_code  <= pending_code;
            blinks       <= pending_code;
            pending_full <= 1'b0;
            oCodeReady   <= 1'b1;
            state        <= pending_nonzero ? ON : IDLE;
            oLed         <= pending_nonzero;
            oBusy        <= pending_nonzero;
          end
        end

        ON: begin
          if (phase == ON_LAST) begin
            state  <= OFF;
            phase  <= '0;
            blinks <= blinks - 1'b1;
            oLed   <= 1'b0;
          end
        end

        OFF: begin
          if (phase == OFF_LAST) begin
            phase <= '0;
            if (blinks != '0) begin
              state <= ON;
              oLed  <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end

        GAP: begin
          if (phase == GAP_LAST) begin
            phase    <= '0;
            oSeqDone <= 1'b1;
            if (pending_full) begin
              active_code  <= pending_code;
              blinks       <= pending_code;
              pending_full <= 1'b0;
              oCodeReady   <= 1'b1;
              state        <= pending_nonzero ? ON : IDLE;
              oLed         <= pending_nonzero;
              oBusy        <= pending_nonzero;
            end else begin
              // No new code waiting: replay the same code from the top.
              blinks <= active_code;
              state  <= ON;
              oLed   <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          phase <= '0;
          oLed  <= 1'b0;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zled_code_blinker.sv
// Bench for zled_code_blinker: a timeline model derived from the sequence period
// is compared against the DUT every cycle, plus literal timing checks.
module tb_zled_code_blinker;

  localparam int CODE_W = 4;
  localparam int ON_C   = 3;
  localparam int OFF_C  = 2;
  localparam int GAP_C  = 5;
  localparam int BLINK  = ON_C + OFF_C;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CODE_W-1:0] code = '0;
  logic              code_valid = 1'b0;
  logic              code_ready;
  logic              led;
  logic              busy;
  logic              seq_done;

  int vectors = 0;
  int miscompares = 0;

  zled_code_blinker #(
    .CODE_W    (CODE_W),
    .ON_CYCLES (ON_C),
    .OFF_CYCLES(OFF_C),
    .GAP_CYCLES(GAP_C)
  ) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iCode     (code),
    .iCodeValid(code_valid),
    .oCodeReady(code_ready),
    .oLed      (led),
    .oBusy     (busy),
    .oSeqDone  (seq_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic got, input logic want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %b want %b", name, $time, got, want);
    end
  endtask

  // Timeline model: a running code N started at edge m_s lights the LED when
  // the position within its period falls in the first ON cycles of a blink slot.
  int t = 0;
  bit model_live = 0;
  bit m_run = 0;
  int m_n = 0;
  int m_s = 0;
  bit m_pend_full = 0;
  int m_pend = 0;
  bit m_ready = 1;
  bit m_led = 0;
  bit m_busy = 0;
  bit m_done = 0;
  bit m_acc;
  int m_pos;
  int m_per;

  always @(posedge clk) begin
    t++;
    if (rst) begin
      model_live  = 1;
      m_run       = 0;
      m_pend_full = 0;
      m_ready     = 1;
      m_done      = 0;
    end else begin
      m_acc  = code_valid && m_ready;
      m_done = 0;
      m_per  = m_n * BLINK + GAP_C;
      if (!m_run) begin
        if (m_pend_full) begin
          m_pend_full = 0;
          if (m_pend != 0) begin
            m_run = 1; m_n = m_pend; m_s = t;
          end
        end
      end else if ((t - m_s) > 0 && ((t - m_s) % m_per) == 0) begin
        m_done = 1;
        if (m_pend_full) begin
          m_pend_full = 0;
          if (m_pend != 0) begin
            m_n = m_pend; m_s = t;
          end else begin
            m_run = 0;
          end
        end
      end
      if (m_acc) begin
        m_pend      = int'(code);
        m_pend_full = 1;
      end
      m_ready = !m_pend_full;
    end
    m_busy = m_run;
    if (m_run) begin
      m_per = m_n * BLINK + GAP_C;
      m_pos = (t - m_s) % m_per;
      m_led = (m_pos < m_n * BLINK) && ((m_pos % BLINK) < ON_C);
    end else begin
      m_led = 0;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("model_led", led, m_led);
      checkOutput("model_ready", code_ready, m_ready);
      checkOutput("model_busy", busy, m_busy);
      checkOutput("model_done", seq_done, m_done);
    end
  end

  // Producer: holds the code until the DUT's ready is seen high before an edge.
  task automatic applyStimulus(input logic [CODE_W-1:0] c, input int max_wait);
    bit sent;
    sent = 0;
    @(posedge clk); #1;
    code = c;
    code_valid = 1'b1;
    for (int w = 0; w < max_wait && !sent; w++) begin
      @(negedge clk);
      if (code_ready === 1'b1) begin
        @(posedge clk); #1;
        sent = 1;
      end
    end
    code_valid = 1'b0;
    if (!sent) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL handshake_timeout code=%0d: got no ready want ready within %0d", c, max_wait);
    end
  endtask

  task automatic waitNegedgeFor(input string name, input int which, input int max_wait);
    bit seen;
    seen = 0;
    for (int w = 0; w < max_wait && !seen; w++) begin
      @(negedge clk);
      case (which)
        0: seen = (seq_done === 1'b1);
        1: seen = (busy === 1'b0);
        default: seen = (led === 1'b1);
      endcase
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_timeout: got no event want event within %0d", name, max_wait);
    end
  endtask

  logic [20:0] exp_led;
  int period;
  int rises;
  int lit;
  logic prev_led;

  initial begin
    // Reset for two cycles and check the idle outputs.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_led", led, 1'b0);
    checkOutput("reset_ready", code_ready, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", seq_done, 1'b0);
    rst = 1'b0;

    // Code 3: literal LED timeline for edges 1..21 after acceptance at edge 0.
    exp_led = 21'b1_0000000_111_00_111_00_111;
    applyStimulus(4'd3, 20);
    checkOutput("c3_ready_edge0", code_ready, 1'b0);
    checkOutput("c3_busy_edge0", busy, 1'b0);
    for (int e = 1; e <= 21; e++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("c3_led_edge%0d", e), led, exp_led[e-1]);
      if (e == 1) begin
        checkOutput("c3_ready_edge1", code_ready, 1'b1);
        checkOutput("c3_busy_edge1", busy, 1'b1);
      end
      if (e == 20) checkOutput("c3_done_edge20", seq_done, 1'b0);
      if (e == 21) checkOutput("c3_done_edge21", seq_done, 1'b1);
    end

    // Backpressure: 2 fills the buffer, 5 waits until the buffer drains.
    applyStimulus(4'd2, 20);
    checkOutput("bp_ready_after_2", code_ready, 1'b0);
    applyStimulus(4'd5, 100);

    // Code 0 lets the current sequence finish and then parks in IDLE.
    applyStimulus(4'd0, 100);
    waitNegedgeFor("idle_after_0", 1, 200);
    checkOutput("c0_led", led, 1'b0);
    checkOutput("c0_busy", busy, 1'b0);
    checkOutput("c0_ready", code_ready, 1'b1);

    // Code 15: measure the period between done pulses and count blinks.
    applyStimulus(4'd15, 20);
    waitNegedgeFor("c15_first_done", 0, 200);
    period = 0;
    rises = 0;
    prev_led = led;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      period++;
      if (led === 1'b1 && prev_led === 1'b0) rises++;
      prev_led = led;
      if (seq_done === 1'b1) break;
    end
    vectors++;
    if (period != 80) begin
      miscompares++;
      $display("[TB] FAIL c15_period: got %0d want 80", period);
    end
    vectors++;
    if (rises != 15) begin
      miscompares++;
      $display("[TB] FAIL c15_blinks: got %0d want 15", rises);
    end

    // Reset mid-ON with a code pending: everything goes dark and stays dark.
    applyStimulus(4'd4, 20);
    applyStimulus(4'd7, 200);
    checkOutput("rst_led_before", led, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_led_after", led, 1'b0);
    checkOutput("rst_busy_after", busy, 1'b0);
    checkOutput("rst_ready_after", code_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    lit = 0;
    for (int w = 0; w < 60; w++) begin
      @(negedge clk);
      if (led !== 1'b0 || busy !== 1'b0) lit++;
    end
    vectors++;
    if (lit != 0) begin
      miscompares++;
      $display("[TB] FAIL rst_pending_dropped: got %0d active cycles want 0", lit);
    end

    // Randomized producer traffic with occasional resets.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1;
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        applyStimulus(CODE_W'($urandom_range(0, 15)), 400);
      end
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    repeat (100) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
